// File: rtl/f4_uart_tx.sv
// f4_uart_tx: memory-mapped 8N1 serial transmitter fed by a small byte FIFO.
// DATA at BASE queues a byte; STATUS at BASE+1 reports flags and a write clears overflow.
module f4_uart_tx #(
    parameter int unsigned   DW     = 16,
    parameter int unsigned   AW     = 16,
    parameter logic [AW-1:0] BASE   = 16'hFF00,
    parameter int unsigned   CLKDIV = 868,
    parameter int unsigned   DEPTH  = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    input  logic          we,
    input  logic          re,
    output logic [DW-1:0] rdata,
    output logic          tx,
    output logic          irq
);

    localparam int unsigned   PW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned   CW        = $clog2(DEPTH + 1);
    localparam int unsigned   BW        = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
    localparam logic [AW-1:0] STAT_ADDR = BASE + AW'(1);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKDIV - 1);
    localparam logic [CW-1:0] CNT_FULL  = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t        state;
    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          overflow;
    logic [7:0]    shift;
    logic [BW-1:0] baud;
    logic [2:0]    bit_idx;

    logic          hit_data_c;
    logic          hit_stat_c;
    logic          push_req_c;
    logic          push_c;
    logic          drop_c;
    logic          pop_c;
    logic          busy_c;
    logic          empty_c;
    logic          full_c;
    logic          baud_done_c;
    logic [7:0]    status_c;
    logic          unused_wdata;

    // Bus decode and FIFO handshake; a push into a full FIFO is still taken when the shifter pops this cycle
    assign hit_data_c  = (addr == BASE);
    assign hit_stat_c  = (addr == STAT_ADDR);
    assign empty_c     = (count == '0);
    assign full_c      = (count == CNT_FULL);
    assign busy_c      = (state != IDLE);
    assign pop_c       = (state == IDLE) && !empty_c;
    assign push_req_c  = we && hit_data_c;
    assign push_c      = push_req_c && (!full_c || pop_c);
    assign drop_c      = push_req_c && !push_c;
    assign baud_done_c = (baud == '0);
    assign status_c    = {4'(count), overflow, busy_c, empty_c, full_c};

    // Only the low byte of a DATA store is transmitted
    assign unused_wdata = ^wdata;

    // FIFO pointers and occupancy; pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_c) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push_c && !pop_c) begin
                count <= count + CW'(1);
            end else if (pop_c && !push_c) begin
                count <= count - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_c) begin
            mem[wr_ptr] <= wdata[7:0];
        end
    end

    // Sticky overflow; cleared by any STATUS store
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (we && hit_stat_c) begin
            overflow <= 1'b0;
        end else if (drop_c) begin
            overflow <= 1'b1;
        end
    end

    // Serial FSM; tx is driven from the current state so the line trails the state by one cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            shift   <= '0;
            baud    <= '0;
            bit_idx <= '0;
            tx      <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (pop_c) begin
                        shift <= mem[rd_ptr];
                        baud  <= BAUD_LAST;
                        state <= START;
                    end
                end
                START: begin
                    tx <= 1'b0;
                    if (baud_done_c) begin
                        baud    <= BAUD_LAST;
                        bit_idx <= '0;
                        state   <= DATA;
                    end else begin
                        baud <= baud - BW'(1);
                    end
                end
                DATA: begin
                    tx <= shift[0];
                    if (baud_done_c) begin
                        baud    <= BAUD_LAST;
                        shift   <= {1'b0, shift[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end
                    end else begin
                        baud <= baud - BW'(1);
                    end
                end
                STOP: begin
                    tx <= 1'b1;
                    if (baud_done_c) begin
                        state <= IDLE;
                    end else begin
                        baud <= baud - BW'(1);
                    end
                end
                default: begin
                    tx    <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

    // Registered read port and all-sent interrupt
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq   <= 1'b1;
            rdata <= '0;
        end else begin
            irq <= empty_c && !busy_c;
            if (re) begin
                rdata <= hit_stat_c ? DW'(status_c) : '0;
            end
        end
    end

endmodule

// File: doc/f4_uart_tx.md
Name: f4_uart_tx

Overview:
Memory-mapped serial output peripheral placed directly downstream of the f4 CPU core on its data bus. It consumes CPU store cycles to two addresses, buffers bytes in a small FIFO and shifts them out as 8N1 asynchronous serial. Programs can then report results off-chip. Status is readable by the CPU so software can poll before writing.

Parameters:
DW, 16, data bus width (must be >= 8)
AW, 16, address bus width
BASE, 16'hFF00, address of DATA register; STATUS register is BASE+1
CLKDIV, 868, clock cycles per serial bit (>= 2)
DEPTH, 4, FIFO entries (power of 2, >= 2)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
addr  in  AW  CPU address
wdata  in  DW  CPU write data
we  in  1  CPU write strobe, one cycle per store
re  in  1  CPU read strobe
rdata  out  DW  read data, registered
tx  out  1  serial line, idle high
irq  out  1  high while FIFO empty and shifter idle (all sent)

Behaviour:
- Reset (async assert, sync release): tx=1, rdata=0, irq=1, FIFO empty (count=0, pointers 0), overflow=0, FSM=IDLE, baud counter=0, bit index=0.
- Decode: a write hits only when addr==BASE or addr==BASE+1; all other addresses are ignored, with no state change.
- DATA write (we, addr==BASE): push wdata[7:0]; upper bits ignored.
- Push acceptance:
  - Accepted if count<DEPTH, or if the FSM pops in the same cycle.
  - Otherwise the byte is dropped and overflow is set (sticky).
- STATUS write (we, addr==BASE+1): clears overflow; data ignored.
- Reads, registered (rdata valid the cycle after re):
  - addr==BASE+1: rdata = {zeros, count[3:0] in bits 7:4, overflow bit3, busy bit2, empty bit1, full bit0}.
  - addr==BASE: returns 0.
  - Any other address: returns 0.
  - rdata holds its value when re=0.
- busy = FSM != IDLE; full = count==DEPTH; empty = count==0.
- FSM:
  - IDLE: tx=1. If FIFO not empty, pop the head into the shift register, load the baud counter, go to START. Pop-to-tx-low latency is 1 cycle (tx falls on the edge after the pop edge).
  - START: tx=0 for CLKDIV cycles, then DATA with index 0.
  - DATA: tx=shift[0] for CLKDIV cycles per bit, LSB first. Shift right after each bit; after bit 7 go to STOP.
  - STOP: tx=1 for CLKDIV cycles, then IDLE.
- Frame length is exactly 10*CLKDIV cycles. When the FIFO is non-empty at STOP end, IDLE pops on the next cycle, so back-to-back frames have exactly 1 idle-high cycle between STOP and the next START.
- Baud counter counts CLKDIV-1 down to 0. The bit advances when it reaches 0. Width is clog2(CLKDIV).
- FIFO:
  - Pointers wrap modulo DEPTH.
  - count updates +1 on push only, -1 on pop only, unchanged on simultaneous push+pop.
  - Pop never happens when empty.
- irq = empty && !busy, registered.
- Reset mid-frame: tx returns high immediately (async), the frame is abandoned, and the FIFO contents are discarded.
- we and re together: both are performed.

Test Plan:
1. CLKDIV=4. Reset, then write 16'h1241 to BASE -> tx low 4 cycles, then bits 1,0,0,0,0,0,1,0 (4 cycles each), high 4 cycles. Frame is 40 cycles. irq falls the cycle after the write, and rises after STOP.
2. CLKDIV=4, DEPTH=4. Write 6 bytes 0x01..0x06 on consecutive cycles. The first byte is popped immediately, so 0x01–0x05 are accepted and 0x06 is dropped. STATUS then reads full=1, overflow=1, count=4. Serial output is 0x01..0x05 in order, 1 idle cycle between frames. A write to BASE+1 clears overflow.
3. FIFO full and the FSM popping in the same cycle as a DATA write -> the write is accepted, count stays 4, overflow stays 0.
4. Wrap-around: send 10 bytes with polling, never exceeding full -> all 10 decoded correctly. Pointers wrap twice with no loss or duplication.
5. Assert rst during the DATA bits of frame 0x55 with 2 bytes queued -> tx=1 within the same cycle. After release, STATUS reads 0x02 (empty), irq=1, and no further frames are sent.
6. Writes and reads to addr=BASE+2 and BASE-1 -> no FIFO change, rdata=0. A read of STATUS with re held for 1 cycle -> rdata updates one cycle later and then holds.
